disp_colour_adapt: RTL and testbench



---
 rtl/disp_colour_pkg.sv | 23 ++
 rtl/disp_colour_adapt_if.sv | 20 ++
 rtl/colour_chan.sv | 66 ++++++
 rtl/disp_colour_adapt.sv | 115 +++++++++++
 tb/tb_disp_colour_adapt.sv | 234 +++++++++++++++++++++++
 5 files changed

// File: rtl/disp_colour_pkg.sv
// Shared constants for the display colour-depth adapter: mode encodings and
// the 4x4 ordered-dither threshold table.
package disp_colour_pkg;

    localparam logic [1:0] MODE_REPL  = 2'd0;
    localparam logic [1:0] MODE_TRUNC = 2'd1;
    localparam logic [1:0] MODE_ROUND = 2'd2;
    localparam logic [1:0] MODE_DITH  = 2'd3;

    function automatic logic [3:0] bayer4(input logic [1:0] x, input logic [1:0] y);
        logic [3:0] v;
        v = 4'd0;
        case ({y, x})
            4'h0: v = 4'd0;  4'h1: v = 4'd8;  4'h2: v = 4'd2;  4'h3: v = 4'd10;
            4'h4: v = 4'd12; 4'h5: v = 4'd4;  4'h6: v = 4'd14; 4'h7: v = 4'd6;
            4'h8: v = 4'd3;  4'h9: v = 4'd11; 4'hA: v = 4'd1;  4'hB: v = 4'd9;
            4'hC: v = 4'd15; 4'hD: v = 4'd7;  4'hE: v = 4'd13; 4'hF: v = 4'd5;
            default: v = 4'd0;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/disp_colour_adapt_if.sv
// Pixel-stream bundle around the adapter: native-depth input side plus the
// converted, delayed output side.
interface disp_colour_adapt_if #(
    parameter int BPC_IN  = 5,
    parameter int BPC_OUT = 8,
    parameter int CORDW   = 16
);
    logic [1:0]         mode;
    logic [CORDW-1:0]   in_x, in_y;
    logic               in_de, in_frame;
    logic [BPC_IN-1:0]  in_r, in_g, in_b;
    logic [CORDW-1:0]   out_x, out_y;
    logic               out_de, out_frame;
    logic [BPC_OUT-1:0] out_r, out_g, out_b;

    modport master (output mode, in_x, in_y, in_de, in_frame, in_r, in_g, in_b,
                    input  out_x, out_y, out_de, out_frame, out_r, out_g, out_b);
    modport slave  (input  mode, in_x, in_y, in_de, in_frame, in_r, in_g, in_b,
                    output out_x, out_y, out_de, out_frame, out_r, out_g, out_b);
endinterface

// File: rtl/colour_chan.sv
// One colour channel: stage 1 registers the biased sum, stage 2 registers the
// expanded or shifted/saturated result (forced to 0 when blanked).
module colour_chan import disp_colour_pkg::*; #(
    parameter int BPC_IN  = 5,
    parameter int BPC_OUT = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               de_i,
    input  logic               pad_i,
    input  logic [BPC_IN-1:0]  pix_i,
    input  logic [BPC_IN:0]    add_i,
    output logic [BPC_OUT-1:0] pix_o
);
    localparam int W = BPC_IN + 1;

    logic [W-1:0]       sum_d, sum_q;
    logic               de_q;
    logic [BPC_OUT-1:0] res_d, pix_q;

    assign sum_d = pad_i ? {1'b0, pix_i} : {1'b0, pix_i} + add_i;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q <= '0;
            de_q  <= 1'b0;
            pix_q <= '0;
        end else begin
            sum_q <= sum_d;
            de_q  <= de_i;
            pix_q <= de_q ? res_d : '0;
        end
    end

    generate
        if (BPC_OUT >= BPC_IN) begin : g_exp
            logic              pad_q;
            logic [BPC_IN-1:0] src;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) pad_q <= 1'b0;
                else        pad_q <= pad_i;
            end

            // Addend is always zero when expanding; the carry test only guards the width.
            assign src = sum_q[W-1] ? '1 : sum_q[BPC_IN-1:0];

            always_comb begin
                res_d = '0;
                if (pad_q) res_d = BPC_OUT'(src) << (BPC_OUT - BPC_IN);
                else for (int i = 0; i < BPC_OUT; i++)
                    res_d[i] = src[BPC_IN-1-((BPC_OUT-1-i) % BPC_IN)];
            end
        end else begin : g_red
            localparam int         D    = BPC_IN - BPC_OUT;
            localparam logic [W-1:0] MAXV = W'((1 << BPC_OUT) - 1);
            logic [W-1:0] shd;

            assign shd   = sum_q >> D;
            assign res_d = (shd > MAXV) ? '1 : shd[BPC_OUT-1:0];
        end
    endgenerate

    assign pix_o = pix_q;

endmodule

// File: rtl/disp_colour_adapt.sv
// Display colour-depth adapter: frame-latched mode, rotating Bayer dither
// threshold, three channel converters and a matching 2-cycle sideband delay.
module disp_colour_adapt import disp_colour_pkg::*; #(
    parameter int         BPC_IN    = 5,
    parameter int         BPC_OUT   = 8,
    parameter int         CORDW     = 16,
    parameter logic [1:0] MODE_DEF  = MODE_REPL,
    parameter bit         FRAME_ROT = 1'b1
) (
    input  logic                    clk_pix,
    input  logic                    rst_pix_n,
    input  logic [1:0]              mode,
    input  logic signed [CORDW-1:0] in_x,
    input  logic signed [CORDW-1:0] in_y,
    input  logic                    in_de,
    input  logic                    in_frame,
    input  logic [BPC_IN-1:0]       in_r,
    input  logic [BPC_IN-1:0]       in_g,
    input  logic [BPC_IN-1:0]       in_b,
    output logic signed [CORDW-1:0] out_x,
    output logic signed [CORDW-1:0] out_y,
    output logic                    out_de,
    output logic                    out_frame,
    output logic [BPC_OUT-1:0]      out_r,
    output logic [BPC_OUT-1:0]      out_g,
    output logic [BPC_OUT-1:0]      out_b
);
    logic [1:0] mode_d, mode_q, fcnt_d, fcnt_q;
    logic       pad;
    logic [BPC_IN:0] add;

    // The frame pixel itself already sees the new mode and rotation step.
    always_comb begin
        mode_d = in_frame ? mode : mode_q;
        fcnt_d = 2'd0;
        if (mode_d == MODE_DITH && FRAME_ROT)
            fcnt_d = in_frame ? fcnt_q + 2'd1 : fcnt_q;
    end

    always_ff @(posedge clk_pix or negedge rst_pix_n) begin
        if (!rst_pix_n) begin
            mode_q <= MODE_DEF;
            fcnt_q <= 2'd0;
        end else begin
            mode_q <= mode_d;
            fcnt_q <= fcnt_d;
        end
    end

    assign pad = (mode_d == MODE_TRUNC);

    generate
        if (BPC_IN > BPC_OUT) begin : g_thr
            localparam int D = BPC_IN - BPC_OUT;
            localparam int W = BPC_IN + 1;
            logic [3:0]   b;
            logic [W-1:0] t;

            assign b = bayer4(in_x[1:0], in_y[1:0]) + {fcnt_d, 2'b00};
            if (D <= 4) begin : g_r
                assign t = W'(b >> (4 - D));
            end else begin : g_l
                assign t = W'(b) << (D - 4);
            end
            assign add = (mode_d == MODE_ROUND) ? W'(1) << (D - 1) :
                         (mode_d == MODE_DITH)  ? t : '0;
        end else begin : g_nothr
            assign add = '0;
        end
    endgenerate

    logic [2:0][BPC_IN-1:0]  cin;
    logic [2:0][BPC_OUT-1:0] cout;
    assign cin = {in_r, in_g, in_b};

    for (genvar c = 0; c < 3; c++) begin : g_ch
        colour_chan #(.BPC_IN(BPC_IN), .BPC_OUT(BPC_OUT)) u_ch (
            .clk   (clk_pix),
            .rst_n (rst_pix_n),
            .de_i  (in_de),
            .pad_i (pad),
            .pix_i (cin[c]),
            .add_i (add),
            .pix_o (cout[c])
        );
    end

    assign out_r = cout[2];
    assign out_g = cout[1];
    assign out_b = cout[0];

    logic [CORDW-1:0] x_q [2];
    logic [CORDW-1:0] y_q [2];
    logic [1:0]       de_q, fr_q;

    always_ff @(posedge clk_pix or negedge rst_pix_n) begin
        if (!rst_pix_n) begin
            x_q[0] <= '0; x_q[1] <= '0;
            y_q[0] <= '0; y_q[1] <= '0;
            de_q   <= '0;
            fr_q   <= '0;
        end else begin
            x_q[0] <= in_x;  x_q[1] <= x_q[0];
            y_q[0] <= in_y;  y_q[1] <= y_q[0];
            de_q   <= {de_q[0], in_de};
            fr_q   <= {fr_q[0], in_frame};
        end
    end

    assign out_x     = x_q[1];
    assign out_y     = y_q[1];
    assign out_de    = de_q[1];
    assign out_frame = fr_q[1];

endmodule

// File: tb/tb_disp_colour_adapt.sv
// Bench for the colour adapter: a 5->8 and an 8->5 instance checked every
// cycle against an arithmetic model, plus hand-computed literal expectations.
module tb_disp_colour_adapt;
    localparam int CW = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic chk_en = 1'b0;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;

    disp_colour_adapt_if #(.BPC_IN(5), .BPC_OUT(8), .CORDW(CW)) ia();
    disp_colour_adapt_if #(.BPC_IN(8), .BPC_OUT(5), .CORDW(CW)) ib();

    disp_colour_adapt #(.BPC_IN(5), .BPC_OUT(8), .CORDW(CW), .MODE_DEF(2'd0), .FRAME_ROT(1'b1)) u_a (
        .clk_pix(clk), .rst_pix_n(rst_n), .mode(ia.mode), .in_x(ia.in_x), .in_y(ia.in_y),
        .in_de(ia.in_de), .in_frame(ia.in_frame), .in_r(ia.in_r), .in_g(ia.in_g), .in_b(ia.in_b),
        .out_x(ia.out_x), .out_y(ia.out_y), .out_de(ia.out_de), .out_frame(ia.out_frame),
        .out_r(ia.out_r), .out_g(ia.out_g), .out_b(ia.out_b));

    disp_colour_adapt #(.BPC_IN(8), .BPC_OUT(5), .CORDW(CW), .MODE_DEF(2'd3), .FRAME_ROT(1'b1)) u_b (
        .clk_pix(clk), .rst_pix_n(rst_n), .mode(ib.mode), .in_x(ib.in_x), .in_y(ib.in_y),
        .in_de(ib.in_de), .in_frame(ib.in_frame), .in_r(ib.in_r), .in_g(ib.in_g), .in_b(ib.in_b),
        .out_x(ib.out_x), .out_y(ib.out_y), .out_de(ib.out_de), .out_frame(ib.out_frame),
        .out_r(ib.out_r), .out_g(ib.out_g), .out_b(ib.out_b));

    typedef struct { int md; int fc; int x; int y; int de; int fr; int r; int g; int b; } ex_t;

    int bay [16] = '{0, 8, 2, 10, 12, 4, 14, 6, 3, 11, 1, 9, 15, 7, 13, 5};

    function automatic int conv(int v, int bin, int bout, int md, int t, int de);
        int acc, n, d, add;
        if (de == 0) return 0;
        if (bout >= bin) begin
            if (md == 1) return v << (bout - bin);
            acc = 0; n = 0;
            while (n < bout) begin acc = (acc << bin) | v; n += bin; end
            return acc >> (n - bout);
        end
        d   = bin - bout;
        add = (md == 2) ? (1 << (d - 1)) : (md == 3) ? t : 0;
        acc = (v + add) >> d;
        if (acc > (1 << bout) - 1) acc = (1 << bout) - 1;
        return acc;
    endfunction

    function automatic ex_t step_model(int bin, int bout, int md, int fc, int mode_in,
                                       int x, int y, int de, int fr, int r, int g, int b);
        ex_t e;
        int d, bb, t;
        if (fr != 0) md = mode_in;
        if (md != 3) fc = 0;
        else if (fr != 0) fc = (fc + 1) % 4;
        d = bin - bout;
        t = 0;
        if (d > 0) begin
            bb = (bay[(y & 3) * 4 + (x & 3)] + 4 * fc) % 16;
            t  = (d <= 4) ? (bb >> (4 - d)) : (bb << (d - 4));
        end
        e.md = md; e.fc = fc; e.x = x; e.y = y; e.de = de; e.fr = fr;
        e.r = conv(r, bin, bout, md, t, de);
        e.g = conv(g, bin, bout, md, t, de);
        e.b = conv(b, bin, bout, md, t, de);
        return e;
    endfunction

    ex_t na, nb, a1, a2, b1, b2;
    int  ma = 0, fa = 0, mb = 3, fb = 0;

    always_comb na = step_model(5, 8, ma, fa, int'(ia.mode), int'(ia.in_x), int'(ia.in_y),
                                int'(ia.in_de), int'(ia.in_frame), int'(ia.in_r), int'(ia.in_g), int'(ia.in_b));
    always_comb nb = step_model(8, 5, mb, fb, int'(ib.mode), int'(ib.in_x), int'(ib.in_y),
                                int'(ib.in_de), int'(ib.in_frame), int'(ib.in_r), int'(ib.in_g), int'(ib.in_b));

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a1 <= '{default:0}; a2 <= '{default:0};
            b1 <= '{default:0}; b2 <= '{default:0};
            ma <= 0; fa <= 0; mb <= 3; fb <= 0;
        end else begin
            a1 <= na; a2 <= a1; ma <= na.md; fa <= na.fc;
            b1 <= nb; b2 <= b1; mb <= nb.md; fb <= nb.fc;
        end
    end

    function automatic logic [71:0] pk(int x, int y, int de, int fr, int r, int g, int b);
        return {x[15:0], y[15:0], 2'b00, de[0], fr[0], r[11:0], g[11:0], b[11:0]};
    endfunction

    task automatic chk(string nm, logic [71:0] act, logic [71:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%h exp=%h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("pipe_a", pk(int'(ia.out_x), int'(ia.out_y), int'(ia.out_de), int'(ia.out_frame),
                             int'(ia.out_r), int'(ia.out_g), int'(ia.out_b)),
                          pk(a2.x, a2.y, a2.de, a2.fr, a2.r, a2.g, a2.b));
            chk("pipe_b", pk(int'(ib.out_x), int'(ib.out_y), int'(ib.out_de), int'(ib.out_frame),
                             int'(ib.out_r), int'(ib.out_g), int'(ib.out_b)),
                          pk(b2.x, b2.y, b2.de, b2.fr, b2.r, b2.g, b2.b));
        end
    end

    task automatic drv_a(int md, int x, int y, int de, int fr, int r, int g, int b);
        ia.mode = 2'(md); ia.in_x = 16'(x); ia.in_y = 16'(y); ia.in_de = 1'(de);
        ia.in_frame = 1'(fr); ia.in_r = 5'(r); ia.in_g = 5'(g); ia.in_b = 5'(b);
    endtask

    task automatic drv_b(int md, int x, int y, int de, int fr, int r, int g, int b);
        ib.mode = 2'(md); ib.in_x = 16'(x); ib.in_y = 16'(y); ib.in_de = 1'(de);
        ib.in_frame = 1'(fr); ib.in_r = 8'(r); ib.in_g = 8'(g); ib.in_b = 8'(b);
    endtask

    task automatic step();
        @(posedge clk); #1;
    endtask

    // One pixel followed by one blank cycle; its result is on the outputs on return.
    task automatic pix_a(int md, int x, int y, int de, int fr, int r, int g, int b);
        drv_a(md, x, y, de, fr, r, g, b); step();
        drv_a(md, 0, 0, 0, 0, 0, 0, 0);   step();
    endtask

    task automatic pix_b(int md, int x, int y, int de, int fr, int r, int g, int b);
        drv_b(md, x, y, de, fr, r, g, b); step();
        drv_b(md, 0, 0, 0, 0, 0, 0, 0);   step();
    endtask

    task automatic chk_zero(string nm);
        chk({nm, "_a"}, pk(int'(ia.out_x), int'(ia.out_y), int'(ia.out_de), int'(ia.out_frame),
                            int'(ia.out_r), int'(ia.out_g), int'(ia.out_b)), 72'h0);
        chk({nm, "_b"}, pk(int'(ib.out_x), int'(ib.out_y), int'(ib.out_de), int'(ib.out_frame),
                            int'(ib.out_r), int'(ib.out_g), int'(ib.out_b)), 72'h0);
    endtask

    initial begin
        drv_a(0, 0, 0, 0, 0, 0, 0, 0);
        drv_b(0, 0, 0, 0, 0, 0, 0, 0);
        #12 chk_zero("reset");
        #1 rst_n = 1'b1;
        step();
        chk_en = 1'b1;

        // 5->8 replicate, with latency pinned
        drv_a(0, 0, 0, 1, 1, 'h1F, 'h10, 'h00); step();
        chk("a_lat1", 72'(ia.out_r), 72'h0);
        drv_a(0, 0, 0, 0, 0, 0, 0, 0); step();
        chk("a_r_1F", 72'(ia.out_r), 72'hFF);
        chk("a_g_10", 72'(ia.out_g), 72'h84);
        chk("a_b_00", 72'(ia.out_b), 72'h00);
        chk("a_frame", 72'(ia.out_frame), 72'h1);

        // zero-pad, mid-frame mode change ignored, then back to replicate
        pix_a(1, 5, 2, 1, 1, 'h10, 'h10, 'h10);
        chk("a_pad_10", 72'(ia.out_r), 72'h80);
        pix_a(0, 6, 2, 1, 0, 'h10, 'h10, 'h10);
        chk("a_midframe", 72'(ia.out_r), 72'h80);
        pix_a(0, 0, 3, 1, 1, 'h10, 'h10, 'h10);
        chk("a_repl_again", 72'(ia.out_r), 72'h84);
        pix_a(0, 7, 3, 0, 0, 'h1F, 'h1F, 'h1F);
        chk("a_blank", 72'(ia.out_r), 72'h0);
        chk("a_blank_x", 72'(ia.out_x), 72'h7);

        // 8->5 dither from reset: fcnt=0
        pix_b(3, 0, 0, 1, 0, 'h0C, 'h0C, 'h0C);
        chk("b_dith00", 72'(ib.out_r), 72'h1);
        pix_b(3, 1, 0, 1, 0, 'h0C, 'h0C, 'h0C);
        chk("b_dith10", 72'(ib.out_r), 72'h2);
        pix_b(3, -1, 0, 1, 0, 'h0C, 'h0C, 'h0C);
        chk("b_negx", 72'(ib.out_r), 72'h2);
        chk("b_negx_x", 72'(ib.out_x), 72'hFFFF);
        // one frame pulse: fcnt=1
        pix_b(3, 0, 0, 1, 1, 'h0C, 'h0C, 'h0C);
        chk("b_f1_00", 72'(ib.out_r), 72'h1);
        pix_b(3, 1, 0, 1, 0, 'h0C, 'h0C, 'h0C);
        chk("b_f1_10", 72'(ib.out_r), 72'h2);
        pix_b(3, 0, 0, 1, 0, 'h0E, 'h0E, 'h0E);
        chk("b_f1_0E", 72'(ib.out_r), 72'h2);

        // truncate and round
        pix_b(1, 0, 0, 1, 1, 'hFF, 'h0C, 'h00);
        chk("b_trunc_FF", 72'(ib.out_r), 72'h1F);
        chk("b_trunc_0C", 72'(ib.out_g), 72'h01);
        pix_b(2, 0, 0, 1, 1, 'h0C, 'hFE, 'h07);
        chk("b_round_0C", 72'(ib.out_r), 72'h02);
        chk("b_round_sat", 72'(ib.out_g), 72'h1F);
        chk("b_round_07", 72'(ib.out_b), 72'h01);

        // four frame pulses in dither: fcnt 1,2,3 then wraps to 0
        pix_b(3, 0, 0, 1, 1, 'h0A, 0, 0); chk("b_wrap1", 72'(ib.out_r), 72'h1);
        pix_b(3, 0, 0, 1, 1, 'h0A, 0, 0); chk("b_wrap2", 72'(ib.out_r), 72'h1);
        pix_b(3, 0, 0, 1, 1, 'h0A, 0, 0); chk("b_wrap3", 72'(ib.out_r), 72'h2);
        pix_b(3, 0, 0, 1, 1, 'h0A, 0, 0); chk("b_wrap4", 72'(ib.out_r), 72'h1);

        // mixed stream, checked by the model each cycle
        for (int i = 0; i < 48; i++) begin
            drv_a((i / 12) % 4, i % 7 - 2, i / 5 - 3, (i % 9 != 8) ? 1 : 0, (i % 12 == 0) ? 1 : 0,
                  (i * 7) & 31, (i * 13) & 31, (i * 3) & 31);
            drv_b((i / 12 + 1) % 4, i % 7 - 2, i / 5 - 3, (i % 9 != 8) ? 1 : 0, (i % 12 == 0) ? 1 : 0,
                  (i * 37) & 255, (i * 91) & 255, 255 - ((i * 11) & 255));
            step();
        end

        // mid-line reset clears outputs at once and restores mode/fcnt
        drv_a(1, 3, 3, 1, 1, 'h15, 'h0A, 'h1F);
        drv_b(3, 3, 3, 1, 1, 'h80, 'h40, 'hF0);
        step();
        drv_a(1, 4, 3, 1, 0, 'h15, 'h0A, 'h1F);
        drv_b(3, 4, 3, 1, 0, 'h80, 'h40, 'hF0);
        step();
        #2 rst_n = 1'b0;
        #1 chk_zero("rst_mid");
        #3 rst_n = 1'b1;
        drv_a(0, 0, 0, 0, 0, 0, 0, 0);
        drv_b(0, 0, 0, 0, 0, 0, 0, 0);
        pix_a(1, 0, 0, 1, 0, 'h10, 'h10, 'h10);
        chk("a_post_rst", 72'(ia.out_r), 72'h84);
        pix_b(1, 0, 0, 1, 0, 'h0E, 'h0E, 'h0E);
        chk("b_post_rst", 72'(ib.out_r), 72'h1);

        step();
        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
